alu_seq: RTL and testbench

- Parametrised, handshaked successor to the combinational datapath ALU.
- Adds iterative multiply and unsigned divide/remainder, signed compare, arithmetic shift, and a full flag set (zero, negative, carry, overflow).
- Sits between the decode/operand-fetch stage and writeback of the core. Uses valid/ready handshakes on both sides so multi-cycle ops can stall the pipeline.

---
 rtl/alu_seq_if.sv | 33 +++
 rtl/alu_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_alu_seq.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_if
// Description : Operand/result handshake bundle between issue and alu_seq.
// Revision    : 1.0
// ============================================================================
interface alu_seq_if #(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      OpCode;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] y;
    logic            zero_f;
    logic            neg_f;
    logic            carry_f;
    logic            ovf_f;

    modport master (
        output in_valid, a, b, OpCode, out_ready,
        input  in_ready, out_valid, y, zero_f, neg_f, carry_f, ovf_f
    );

    modport slave (
        input  in_valid, a, b, OpCode, out_ready,
        output in_ready, out_valid, y, zero_f, neg_f, carry_f, ovf_f
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Handshaked ALU with single-cycle logic/arith/shift ops and
//               iterative MUL / DIVU / REMU (one bit per cycle).
// Revision    : 1.0
// ============================================================================
module alu_seq #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  wire logic clk,
    input  wire logic rst,
    alu_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_REMU = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_SLT  = 4'b1100;
    localparam logic [3:0] OP_SLTU = 4'b1101;
    localparam logic [3:0] OP_MUL  = 4'b1110;
    localparam logic [3:0] OP_DIVU = 4'b1111;

    localparam logic [SHW:0]  ITERS    = (SHW+1)'(XLEN);
    localparam logic [SHW:0]  CNT_ONE  = (SHW+1)'(1);
    localparam logic [XLEN:0] WIDE_ONE = (XLEN+1)'(1);

    state_t          state_q, state_d;
    logic [XLEN-1:0] y_q, y_d;
    logic            zero_q, zero_d;
    logic            neg_q, neg_d;
    logic            carry_q, carry_d;
    logic            ovf_q, ovf_d;
    logic [SHW:0]    cnt_q, cnt_d;
    logic [3:0]      op_q, op_d;
    // acc: product (MUL) or partial remainder (DIV); x: multiplicand or
    // dividend/quotient shift register; m: multiplier or divisor.
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] x_q, x_d;
    logic [XLEN-1:0] m_q, m_d;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [XLEN:0]   sum_add;
    logic [XLEN:0]   sum_sub;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_y;
    logic            alu_c;
    logic            alu_v;
    logic            is_multi;

    always_comb begin
        sum_add = {1'b0, bus.a} + {1'b0, bus.b};
        sum_sub = {1'b0, bus.a} + {1'b0, ~bus.b} + WIDE_ONE;
        shamt   = bus.b[SHW-1:0];
        alu_y   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (bus.OpCode)
            OP_AND:  alu_y = bus.a & bus.b;
            OP_OR:   alu_y = bus.a | bus.b;
            OP_XOR:  alu_y = bus.a ^ bus.b;
            OP_ADD: begin
                alu_y = sum_add[XLEN-1:0];
                alu_c = sum_add[XLEN];
                alu_v = (bus.a[XLEN-1] == bus.b[XLEN-1]) &&
                        (sum_add[XLEN-1] != bus.a[XLEN-1]);
            end
            OP_SUB: begin
                alu_y = sum_sub[XLEN-1:0];
                alu_c = sum_sub[XLEN];
                alu_v = (bus.a[XLEN-1] != bus.b[XLEN-1]) &&
                        (sum_sub[XLEN-1] != bus.a[XLEN-1]);
            end
            OP_SLT:  alu_y = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: alu_y = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
            OP_SLL:  alu_y = bus.a << shamt;
            OP_SRL:  alu_y = bus.a >> shamt;
            OP_SRA:  alu_y = $unsigned($signed(bus.a) >>> shamt);
            default: alu_y = '0;
        endcase
        is_multi = (bus.OpCode == OP_MUL) || (bus.OpCode == OP_DIVU) ||
                   (bus.OpCode == OP_REMU);
    end

    // ------------------------------------------------------------------
    // One iteration of shift-add multiply / restoring divide
    // ------------------------------------------------------------------
    logic [XLEN-1:0] mul_acc;
    logic [XLEN:0]   div_sh;
    logic [XLEN:0]   div_diff;
    logic            div_ge;
    logic [XLEN-1:0] div_rem;
    logic [XLEN-1:0] div_quo;

    always_comb begin
        mul_acc  = m_q[0] ? (acc_q + x_q) : acc_q;
        div_sh   = {acc_q, x_q[XLEN-1]};
        div_diff = div_sh - {1'b0, m_q};
        div_ge   = ~div_diff[XLEN];
        div_rem  = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
        div_quo  = {x_q[XLEN-2:0], div_ge};
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic            load_res;
    logic [XLEN-1:0] res;
    logic            res_c;
    logic            res_v;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        x_d      = x_q;
        m_d      = m_q;
        y_d      = y_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        load_res = 1'b0;
        res      = '0;
        res_c    = 1'b0;
        res_v    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (is_multi) begin
                        op_d    = bus.OpCode;
                        acc_d   = '0;
                        x_d     = bus.a;
                        m_d     = bus.b;
                        cnt_d   = ITERS;
                        state_d = BUSY;
                    end else begin
                        load_res = 1'b1;
                        res      = alu_y;
                        res_c    = alu_c;
                        res_v    = alu_v;
                        state_d  = DONE;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_ONE;
                if (op_q == OP_MUL) begin
                    acc_d = mul_acc;
                    x_d   = x_q << 1;
                    m_d   = m_q >> 1;
                end else begin
                    acc_d = div_rem;
                    x_d   = div_quo;
                end
                if (cnt_q == CNT_ONE) begin
                    load_res = 1'b1;
                    unique case (op_q)
                        OP_MUL:  res = mul_acc;
                        OP_DIVU: res = div_quo;
                        default: res = div_rem;
                    endcase
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_res) begin
            y_d     = res;
            zero_d  = (res == '0);
            neg_d   = res[XLEN-1];
            carry_d = res_c;
            ovf_d   = res_v;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= '0;
            zero_q  <= 1'b1;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            m_q     <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            m_q     <= m_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.y         = y_q;
    assign bus.zero_f    = zero_q;
    assign bus.neg_f     = neg_q;
    assign bus.carry_f   = carry_q;
    assign bus.ovf_f     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed self-checking bench for alu_seq (XLEN=32).
// Revision    : 1.0
// ============================================================================
module tb_alu_seq;

    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_REMU = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_SLT  = 4'b1100;
    localparam logic [3:0] OP_SLTU = 4'b1101;
    localparam logic [3:0] OP_MUL  = 4'b1110;
    localparam logic [3:0] OP_DIVU = 4'b1111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    alu_seq_if #(.XLEN(32)) bus_if ();

    alu_seq #(.XLEN(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Stimulus helpers; all run in the phase 1 time unit after a rising edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
        int n = 0;
        while (!bus_if.in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        bus_if.OpCode   = op;
        bus_if.a        = av;
        bus_if.b        = bv;
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output int busy);
        lat  = 1;
        busy = 0;
        while (!bus_if.out_valid && lat < 100) begin
            if (!bus_if.in_ready) busy++;
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic consume();
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        bus_if.a         = '0;
        bus_if.b         = '0;
        bus_if.OpCode    = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_total++; if (bus_if.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus_if.in_ready); else n_pass++;
        n_total++; if (bus_if.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus_if.out_valid); else n_pass++;
        n_total++; if (bus_if.y !== 32'h0) $display("FAIL reset_y: got %h want 00000000", bus_if.y); else n_pass++;
        n_total++; if ({bus_if.zero_f, bus_if.neg_f, bus_if.carry_f, bus_if.ovf_f} !== 4'b1000)
            $display("FAIL reset_flags(znco): got %b want 1000", {bus_if.zero_f, bus_if.neg_f, bus_if.carry_f, bus_if.ovf_f}); else n_pass++;
    endtask

    task automatic test_add();
        int lat, busy;
        issue(OP_ADD, 32'h7FFF_FFFF, 32'h1);
        wait_out(lat, busy);
        n_total++; if (lat != 1) $display("FAIL add_latency: got %0d want 1", lat); else n_pass++;
        n_total++; if (bus_if.y !== 32'h8000_0000) $display("FAIL add_y: got %h want 80000000", bus_if.y); else n_pass++;
        n_total++; if ({bus_if.zero_f, bus_if.neg_f, bus_if.carry_f, bus_if.ovf_f} !== 4'b0101)
            $display("FAIL add_flags(znco): got %b want 0101", {bus_if.zero_f, bus_if.neg_f, bus_if.carry_f, bus_if.ovf_f}); else n_pass++;
        consume();
        n_total++; if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1)
            $display("FAIL add_release: got out_valid=%b in_ready=%b want 0 1", bus_if.out_valid, bus_if.in_ready); else n_pass++;
    endtask

    task automatic test_sub_slt();
        int lat, busy;
        issue(OP_SUB, 32'd5, 32'd5);
        wait_out(lat, busy);
        n_total++; if (bus_if.y !== 32'h0) $display("FAIL sub_eq_y: got %h want 00000000", bus_if.y); else n_pass++;
        n_total++; if ({bus_if.zero_f, bus_if.neg_f, bus_if.carry_f, bus_if.ovf_f} !== 4'b1010)
            $display("FAIL sub_eq_flags(znco): got %b want 1010", {bus_if.zero_f, bus_if.neg_f, bus_if.carry_f, bus_if.ovf_f}); else n_pass++;
        consume();
        issue(OP_SUB, 32'h8000_0000, 32'h1);
        wait_out(lat, busy);
        n_total++; if (bus_if.y !== 32'h7FFF_FFFF) $display("FAIL sub_ovf_y: got %h want 7fffffff", bus_if.y); else n_pass++;
        n_total++; if ({bus_if.zero_f, bus_if.neg_f, bus_if.carry_f, bus_if.ovf_f} !== 4'b0011)
            $display("FAIL sub_ovf_flags(znco): got %b want 0011", {bus_if.zero_f, bus_if.neg_f, bus_if.carry_f, bus_if.ovf_f}); else n_pass++;
        consume();
        issue(OP_SLT, 32'hFFFF_FFFF, 32'h1);
        wait_out(lat, busy);
        n_total++; if (bus_if.y !== 32'h1) $display("FAIL slt_y: got %h want 00000001", bus_if.y); else n_pass++;
        n_total++; if (bus_if.carry_f !== 1'b0 || bus_if.zero_f !== 1'b0)
            $display("FAIL slt_flags: got carry=%b zero=%b want 0 0", bus_if.carry_f, bus_if.zero_f); else n_pass++;
        consume();
        issue(OP_SLTU, 32'hFFFF_FFFF, 32'h1);
        wait_out(lat, busy);
        n_total++; if (bus_if.y !== 32'h0 || bus_if.zero_f !== 1'b1)
            $display("FAIL sltu_y: got y=%h zero=%b want 00000000 1", bus_if.y, bus_if.zero_f); else n_pass++;
        consume();
    endtask

    task automatic test_logic_shift();
        int lat, busy;
        issue(OP_AND, 32'h0000_F0F0, 32'h0000_0FF0);
        wait_out(lat, busy);
        n_total++; if (bus_if.y !== 32'h0000_00F0) $display("FAIL and_y: got %h want 000000f0", bus_if.y); else n_pass++;
        consume();
        issue(OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000);
        wait_out(lat, busy);
        n_total++; if (bus_if.y !== 32'h5555_5555) $display("FAIL xor_y: got %h want 55555555", bus_if.y); else n_pass++;
        consume();
        issue(OP_SLL, 32'h1, 32'h3F);
        wait_out(lat, busy);
        n_total++; if (bus_if.y !== 32'h8000_0000 || bus_if.neg_f !== 1'b1)
            $display("FAIL sll_y: got y=%h neg=%b want 80000000 1", bus_if.y, bus_if.neg_f); else n_pass++;
        consume();
        issue(OP_SRL, 32'h8000_0000, 32'h4);
        wait_out(lat, busy);
        n_total++; if (bus_if.y !== 32'h0800_0000) $display("FAIL srl_y: got %h want 08000000", bus_if.y); else n_pass++;
        consume();
        issue(4'b0000, 32'h1234_5678, 32'h1);
        wait_out(lat, busy);
        n_total++; if (lat != 1 || bus_if.y !== 32'h0 || bus_if.zero_f !== 1'b1)
            $display("FAIL undef_op: got lat=%0d y=%h zero=%b want 1 00000000 1", lat, bus_if.y, bus_if.zero_f); else n_pass++;
        consume();
    endtask

    task automatic test_mul();
        int lat, busy;
        issue(OP_MUL, 32'd7, 32'd6);
        wait_out(lat, busy);
        n_total++; if (busy != 32) $display("FAIL mul_busy_cycles: got %0d want 32", busy); else n_pass++;
        n_total++; if (lat != 33) $display("FAIL mul_latency: got %0d want 33", lat); else n_pass++;
        n_total++; if (bus_if.y !== 32'd42) $display("FAIL mul_y: got %h want 0000002a", bus_if.y); else n_pass++;
        consume();
        issue(OP_MUL, 32'hFFFF_FFFF, 32'd2);
        wait_out(lat, busy);
        n_total++; if (bus_if.y !== 32'hFFFF_FFFE) $display("FAIL mul_wrap_y: got %h want fffffffe", bus_if.y); else n_pass++;
        n_total++; if ({bus_if.zero_f, bus_if.neg_f, bus_if.carry_f, bus_if.ovf_f} !== 4'b0100)
            $display("FAIL mul_flags(znco): got %b want 0100", {bus_if.zero_f, bus_if.neg_f, bus_if.carry_f, bus_if.ovf_f}); else n_pass++;
        consume();
    endtask

    task automatic test_div();
        int lat, busy;
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_out(lat, busy);
        n_total++; if (lat != 33 || bus_if.y !== 32'd14)
            $display("FAIL divu_y: got lat=%0d y=%h want 33 0000000e", lat, bus_if.y); else n_pass++;
        consume();
        issue(OP_REMU, 32'd100, 32'd7);
        wait_out(lat, busy);
        n_total++; if (bus_if.y !== 32'd2) $display("FAIL remu_y: got %h want 00000002", bus_if.y); else n_pass++;
        consume();
        issue(OP_DIVU, 32'd9, 32'd0);
        wait_out(lat, busy);
        n_total++; if (bus_if.y !== 32'hFFFF_FFFF) $display("FAIL divu_by0_y: got %h want ffffffff", bus_if.y); else n_pass++;
        consume();
        issue(OP_REMU, 32'd9, 32'd0);
        wait_out(lat, busy);
        n_total++; if (bus_if.y !== 32'd9) $display("FAIL remu_by0_y: got %h want 00000009", bus_if.y); else n_pass++;
        consume();
    endtask

    task automatic test_backpressure();
        int lat, busy, bad;
        issue(OP_SRA, 32'h8000_0000, 32'h21);
        wait_out(lat, busy);
        n_total++; if (bus_if.y !== 32'hC000_0000) $display("FAIL sra_y: got %h want c0000000", bus_if.y); else n_pass++;
        // Offer another op while stalled; it must not be taken.
        bus_if.OpCode   = OP_ADD;
        bus_if.a        = 32'd1;
        bus_if.b        = 32'd1;
        bus_if.in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus_if.y !== 32'hC000_0000 || bus_if.out_valid !== 1'b1 || bus_if.in_ready !== 1'b0 ||
                {bus_if.zero_f, bus_if.neg_f, bus_if.carry_f, bus_if.ovf_f} !== 4'b0100)
                bad++;
        end
        bus_if.in_valid = 1'b0;
        n_total++; if (bad != 0) $display("FAIL hold_stable: got %0d unstable cycles want 0", bad); else n_pass++;
        consume();
        n_total++; if (bus_if.out_valid !== 1'b0 || bus_if.in_ready !== 1'b1)
            $display("FAIL hold_release: got out_valid=%b in_ready=%b want 0 1", bus_if.out_valid, bus_if.in_ready); else n_pass++;
    endtask

    task automatic test_reset_busy();
        int lat, busy, seen;
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_total++; if (bus_if.in_ready !== 1'b1 || bus_if.out_valid !== 1'b0 || bus_if.y !== 32'h0 || bus_if.zero_f !== 1'b1)
            $display("FAIL abort_state: got in_ready=%b out_valid=%b y=%h zero=%b want 1 0 00000000 1",
                     bus_if.in_ready, bus_if.out_valid, bus_if.y, bus_if.zero_f); else n_pass++;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus_if.out_valid) seen++;
        end
        n_total++; if (seen != 0) $display("FAIL abort_no_result: got %0d valid cycles want 0", seen); else n_pass++;
        issue(OP_ADD, 32'd2, 32'd3);
        wait_out(lat, busy);
        n_total++; if (lat != 1 || bus_if.y !== 32'd5)
            $display("FAIL post_abort_add: got lat=%0d y=%h want 1 00000005", lat, bus_if.y); else n_pass++;
        consume();
    endtask

    task automatic test_back_to_back();
        int lat, busy;
        issue(OP_SUB, 32'd3, 32'd5);
        wait_out(lat, busy);
        n_total++; if (bus_if.y !== 32'hFFFF_FFFE) $display("FAIL b2b_sub_y: got %h want fffffffe", bus_if.y); else n_pass++;
        n_total++; if ({bus_if.zero_f, bus_if.neg_f, bus_if.carry_f, bus_if.ovf_f} !== 4'b0100)
            $display("FAIL b2b_sub_flags(znco): got %b want 0100", {bus_if.zero_f, bus_if.neg_f, bus_if.carry_f, bus_if.ovf_f}); else n_pass++;
        consume();
        issue(OP_ADD, 32'hFFFF_FFFF, 32'h1);
        wait_out(lat, busy);
        n_total++; if (lat != 1 || bus_if.y !== 32'h0)
            $display("FAIL b2b_add_y: got lat=%0d y=%h want 1 00000000", lat, bus_if.y); else n_pass++;
        n_total++; if ({bus_if.zero_f, bus_if.neg_f, bus_if.carry_f, bus_if.ovf_f} !== 4'b1010)
            $display("FAIL b2b_add_flags(znco): got %b want 1010", {bus_if.zero_f, bus_if.neg_f, bus_if.carry_f, bus_if.ovf_f}); else n_pass++;
        consume();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_slt();
        test_logic_shift();
        test_mul();
        test_div();
        test_backpressure();
        test_reset_busy();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
